// File: rtl/rsa_block_sequencer.sv
// Sequences one RSA decryption batch: fetch d and n, then read c[k], run the core, and write m[k] back in place.
// Optional watchdog on every wait state is enabled with `define RSA_SEQ_TIMEOUT_EN.
module rsa_block_sequencer #(
  parameter int          DATA_W     = 256,
  parameter int          ADDR_W     = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          NUM_BLOCKS = 38,
  parameter int          CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avm_m0_waitrequest,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  output logic [DATA_W-1:0] avm_m0_writedata,
  input  logic              avm_m0_readdatavalid,
  output logic              avs_s0_waitrequest,
  input  logic              avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  output logic [7:0]        avs_s0_readdata,
  input  logic [7:0]        avs_s0_writedata,
  output logic              core_start,
  output logic [DATA_W-1:0] core_d,
  output logic [DATA_W-1:0] core_n,
  output logic [DATA_W-1:0] core_c,
  input  logic [DATA_W-1:0] core_m,
  input  logic              core_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_D_REQ, S_RD_D_WAIT, S_RD_N_REQ, S_RD_N_WAIT,
    S_RD_C_REQ, S_RD_C_WAIT, S_CORE_GO, S_CORE_WAIT, S_WR_M
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BLOCKS - 1);

  state_t           state;
  logic [CNT_W-1:0] index;
  logic             done_q;
  logic             err_q;
  logic             start;
  logic             wd_expire;
  logic             unused;

  // Ciphertext word k sits one 32-byte line per index above d and n; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] c_addr(input logic [CNT_W-1:0] idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(64) + (ADDR_W'(idx) << 5);
  endfunction

  assign start              = avs_s0_write && !avs_s0_address && avs_s0_writedata[0];
  assign avs_s0_waitrequest = 1'b0;
  assign unused             = ^{avs_s0_read, avs_s0_writedata[7:1]};

  always_comb begin
    avs_s0_readdata = 8'(index);
    if (!avs_s0_address)
      avs_s0_readdata = (state != S_IDLE) ? 8'hFF : {6'b0, err_q, done_q};
  end

`ifdef RSA_SEQ_TIMEOUT_EN
  logic [15:0] wdog;
  state_t      state_d;
  logic        in_wait;

  assign in_wait   = (state == S_RD_D_WAIT) || (state == S_RD_N_WAIT) ||
                     (state == S_RD_C_WAIT) || (state == S_CORE_WAIT);
  assign wd_expire = in_wait && (wdog == 16'hFFFF);

  // Comparing against last cycle's state makes any transition reload the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog    <= 16'h0;
      state_d <= S_IDLE;
    end else begin
      state_d <= state;
      if (state != state_d) wdog <= 16'h0;
      else if (in_wait)     wdog <= wdog + 16'd1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err_q     = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      index            <= '0;
      done_q           <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
      err_q            <= 1'b0;
`endif
      avm_m0_address   <= '0;
      avm_m0_read      <= 1'b0;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= '0;
      core_start       <= 1'b0;
      core_d           <= '0;
      core_n           <= '0;
      core_c           <= '0;
    end else begin
      core_start <= 1'b0;
      if (wd_expire) begin
        avm_m0_read  <= 1'b0;
        avm_m0_write <= 1'b0;
        state        <= S_IDLE;
`ifdef RSA_SEQ_TIMEOUT_EN
        err_q        <= 1'b1;
`endif
      end else begin
        case (state)
          S_IDLE: if (start) begin
            done_q         <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
            index          <= '0;
            avm_m0_read    <= 1'b1;
            avm_m0_address <= ADDR_W'(BASE_ADDR);
            state          <= S_RD_D_REQ;
          end
          S_RD_D_REQ: if (!avm_m0_waitrequest) begin
            avm_m0_read <= 1'b0;
            state       <= S_RD_D_WAIT;
          end
          S_RD_D_WAIT: if (avm_m0_readdatavalid) begin
            core_d         <= avm_m0_readdata;
            avm_m0_read    <= 1'b1;
            avm_m0_address <= ADDR_W'(BASE_ADDR) + ADDR_W'(32);
            state          <= S_RD_N_REQ;
          end
          S_RD_N_REQ: if (!avm_m0_waitrequest) begin
            avm_m0_read <= 1'b0;
            state       <= S_RD_N_WAIT;
          end
          S_RD_N_WAIT: if (avm_m0_readdatavalid) begin
            core_n         <= avm_m0_readdata;
            avm_m0_read    <= 1'b1;
            avm_m0_address <= c_addr(index);
            state          <= S_RD_C_REQ;
          end
          S_RD_C_REQ: if (!avm_m0_waitrequest) begin
            avm_m0_read <= 1'b0;
            state       <= S_RD_C_WAIT;
          end
          S_RD_C_WAIT: if (avm_m0_readdatavalid) begin
            core_c     <= avm_m0_readdata;
            core_start <= 1'b1;
            state      <= S_CORE_GO;
          end
          S_CORE_GO: state <= S_CORE_WAIT;
          S_CORE_WAIT: if (core_done) begin
            avm_m0_writedata <= core_m;
            avm_m0_write     <= 1'b1;
            state            <= S_WR_M;
          end
          // The address register still holds c[index], so plaintext lands in place.
          S_WR_M: if (!avm_m0_waitrequest) begin
            avm_m0_write <= 1'b0;
            if (index == LAST_IDX) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              index          <= index + CNT_W'(1);
              avm_m0_read    <= 1'b1;
              avm_m0_address <= c_addr(index + CNT_W'(1));
              state          <= S_RD_C_REQ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_block_sequencer.sv
// Directed bench for rsa_block_sequencer: memory and core models, two-block batches,
// stalls, stray strobes, mid-batch reset, and the optional watchdog.
module tb_rsa_block_sequencer;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int NB = 2;

  localparam logic [DW-1:0] D_VAL  = {8{32'hDEAD0001}};
  localparam logic [DW-1:0] N_VAL  = {8{32'h0BAD0002}};
  localparam logic [DW-1:0] C0_VAL = {8{32'hC0C00000}};
  localparam logic [DW-1:0] C1_VAL = {8{32'hC1C11111}};
  localparam logic [DW-1:0] ONE    = 256'h1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          avm_m0_waitrequest = 1'b0;
  logic [AW-1:0] avm_m0_address;
  logic          avm_m0_read, avm_m0_write;
  logic [DW-1:0] avm_m0_readdata = '0;
  logic [DW-1:0] avm_m0_writedata;
  logic          avm_m0_readdatavalid = 1'b0;
  logic          avs_s0_waitrequest;
  logic          avs_s0_address = 1'b0;
  logic          avs_s0_read = 1'b0;
  logic          avs_s0_write = 1'b0;
  logic [7:0]    avs_s0_readdata;
  logic [7:0]    avs_s0_writedata = 8'h0;
  logic          core_start;
  logic [DW-1:0] core_d, core_n, core_c;
  logic [DW-1:0] core_m = '0;
  logic          core_done = 1'b0;

  rsa_block_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .NUM_BLOCKS(NB), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset),
    .avm_m0_waitrequest(avm_m0_waitrequest), .avm_m0_address(avm_m0_address),
    .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
    .avm_m0_readdata(avm_m0_readdata), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .avs_s0_waitrequest(avs_s0_waitrequest), .avs_s0_address(avs_s0_address),
    .avs_s0_read(avs_s0_read), .avs_s0_write(avs_s0_write),
    .avs_s0_readdata(avs_s0_readdata), .avs_s0_writedata(avs_s0_writedata),
    .core_start(core_start), .core_d(core_d), .core_n(core_n), .core_c(core_c),
    .core_m(core_m), .core_done(core_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  int            n_total = 0;
  int            n_bad = 0;
  logic [DW-1:0] mem [0:7];
  xfer_t         log_q [$];
  int            stall_cfg = 0;
  int            stall_cnt = 0;
  bit            in_stall = 0;
  logic [AW-1:0] hold_addr;
  logic          hold_rd, hold_wr;
  bit            rd_pend = 0;
  logic [AW-1:0] rd_addr;
  bit            no_rdv = 0;
  bit            stray_en = 0;
  int            core_cnt = 0;
  logic [DW-1:0] c_lat;
  int            starts = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory acceptance happens on the edge; responses are driven on the falling edge.
  always @(posedge clk) begin
    if (reset && (avm_m0_read || avm_m0_write) && !avm_m0_waitrequest) begin
      log_q.push_back('{avm_m0_write, avm_m0_address, avm_m0_writedata});
      if (avm_m0_write) mem[avm_m0_address[7:5]] = avm_m0_writedata;
      else if (!no_rdv) begin
        rd_pend = 1;
        rd_addr = avm_m0_address;
      end
      stall_cnt = 0;
      in_stall  = 0;
    end
  end

  always @(negedge clk) begin
    avm_m0_readdatavalid = 1'b0;
    core_done            = 1'b0;
    if (!reset) begin
      avm_m0_waitrequest = 1'b0;
      rd_pend = 0; core_cnt = 0; stall_cnt = 0; in_stall = 0;
    end else begin
      if (rd_pend) begin
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = mem[rd_addr[7:5]];
        rd_pend = 0;
      end
      avm_m0_waitrequest = 1'b0;
      if (avm_m0_read || avm_m0_write) begin
        if (in_stall) begin
          check("stall_addr_hold", avm_m0_address, hold_addr);
          check("stall_rw_hold", {avm_m0_read, avm_m0_write}, {hold_rd, hold_wr});
        end
        if (stall_cnt < stall_cfg) begin
          if (!in_stall) begin
            hold_addr = avm_m0_address;
            hold_rd   = avm_m0_read;
            hold_wr   = avm_m0_write;
            in_stall  = 1;
          end
          avm_m0_waitrequest = 1'b1;
          stall_cnt++;
        end
      end
      check("no_rd_and_wr", avm_m0_read && avm_m0_write, 0);
      // Core model: fixed 10-cycle latency, m = c ^ 1.
      if (core_start) begin
        starts++;
        check("core_d_at_start", core_d, D_VAL);
        check("core_n_at_start", core_n, N_VAL);
        c_lat    = core_c;
        core_cnt = 10;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_m    = c_lat ^ ONE;
        end else if (stray_en && core_cnt == 5) begin
          avm_m0_readdatavalid = 1'b1;
          avm_m0_readdata      = '1;
        end
      end else if (stray_en && avm_m0_read) begin
        core_done = 1'b1;
        core_m    = {8{32'hBADBAD00}};
      end
    end
  end

  task automatic sread(input logic a, output logic [7:0] v);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    #1;
    v = avs_s0_readdata;
    avs_s0_read    = 1'b0;
  endtask

  task automatic swrite(input logic [7:0] v);
    @(negedge clk);
    avs_s0_address   = 1'b0;
    avs_s0_writedata = v;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = D_VAL; mem[1] = N_VAL; mem[2] = C0_VAL; mem[3] = C1_VAL;
  endtask

  task automatic check_batch(input string pfx);
    logic [AW-1:0] exp_addr [6];
    bit            exp_wr   [6];
    logic [DW-1:0] exp_data [6];
    exp_addr = '{32'h00, 32'h20, 32'h40, 32'h40, 32'h60, 32'h60};
    exp_wr   = '{0, 0, 0, 1, 0, 1};
    exp_data = '{'0, '0, '0, C0_VAL ^ ONE, '0, C1_VAL ^ ONE};
    check({pfx, "_nxfer"}, log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check($sformatf("%s_addr%0d", pfx, i), log_q[i].addr, exp_addr[i]);
      check($sformatf("%s_wr%0d", pfx, i), log_q[i].wr, exp_wr[i]);
      if (exp_wr[i]) check($sformatf("%s_data%0d", pfx, i), log_q[i].data, exp_data[i]);
    end
    check({pfx, "_mem_m0"}, mem[2], C0_VAL ^ ONE);
    check({pfx, "_mem_m1"}, mem[3], C1_VAL ^ ONE);
    check({pfx, "_starts"}, starts, NB);
  endtask

  task automatic run_batch(input string pfx, input bit poke);
    logic [7:0] st;
    bit         fin;
    log_q.delete();
    starts = 0;
    load_mem();
    swrite(8'h01);
    fin = 0;
    st  = 8'h00;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      sread(1'b0, st);
      if (cyc == 4) check({pfx, "_status_busy"}, st, 8'hFF);
      if (st == 8'h01) fin = 1;
      if (poke && cyc == 15) swrite(8'h01);
    end
    check({pfx, "_finished"}, fin, 1);
    check({pfx, "_status_done"}, st, 8'h01);
    sread(1'b1, st);
    check({pfx, "_index_last"}, st, NB - 1);
    check_batch(pfx);
  endtask

  initial begin
    logic [7:0] st;
    bit         hit;
    load_mem();
    repeat (3) @(negedge clk);
    #1;
    check("rst_read", avm_m0_read, 0);
    check("rst_write", avm_m0_write, 0);
    check("rst_addr", avm_m0_address, 0);
    check("rst_wdata", avm_m0_writedata, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_dnc", {core_d ^ core_n ^ core_c}, 0);
    sread(1'b0, st);
    check("rst_status", st, 8'h00);
    sread(1'b1, st);
    check("rst_index", st, 8'h00);
    reset = 1'b1;

    run_batch("zw", 0);

    stall_cfg = 3;
    run_batch("stall", 0);
    stall_cfg = 0;

    stray_en = 1;
    run_batch("stray", 1);
    stray_en = 0;

    // Reset while block 1 is inside the core.
    log_q.delete();
    starts = 0;
    load_mem();
    swrite(8'h01);
    hit = 0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      if (starts == 2) hit = 1;
    end
    check("mid_reset_reached", hit, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_read", avm_m0_read, 0);
    check("mid_rst_write", avm_m0_write, 0);
    check("mid_rst_addr", avm_m0_address, 0);
    check("mid_rst_wdata", avm_m0_writedata, 0);
    check("mid_rst_core", {core_start, core_d, core_n, core_c}, 0);
    sread(1'b0, st);
    check("mid_rst_status", st, 8'h00);
    sread(1'b1, st);
    check("mid_rst_index", st, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_batch("rerun", 0);

`ifdef RSA_SEQ_TIMEOUT_EN
    begin
      int waited;
      no_rdv = 1;
      load_mem();
      swrite(8'h01);
      waited = 0;
      st     = 8'hFF;
      for (int cyc = 0; cyc < 70000 && st != 8'h02; cyc++) begin
        @(negedge clk);
        sread(1'b0, st);
        waited++;
      end
      check("wd_status", st, 8'h02);
      check("wd_read_low", avm_m0_read, 0);
      check("wd_not_early", waited >= 65000, 1);
      no_rdv = 0;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
